vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter H_TOTAL_EXP, default 800, meaning expected clocks per line.
REQ-002 SHALL have parameter V_TOTAL_EXP, default 525, meaning expected lines per frame.
REQ-003 SHALL have parameter H_START, default 144, meaning the hcount of the first active pixel.
REQ-004 SHALL have parameter V_START, default 35, meaning the vcount of the first active line.
REQ-005 SHALL have parameter H_ACTIVE, default 640, and parameter V_ACTIVE, default 480, meaning active pixels per line and active lines per frame.
REQ-006 SHALL have parameter LOCK_FRAMES, default 2, meaning consecutive good frames needed to lock.
REQ-007 SHALL have ports, in this order:
  clk  in  1  pixel clock; all logic on its rising edge
  reset_n  in  1  asynchronous, active-low reset
  vga_h_sync  in  1  horizontal sync, active-low, asynchronous to clk
  vga_v_sync  in  1  vertical sync, active-low, asynchronous to clk
  hpos  out  10  recovered column, 0..H_ACTIVE-1
  vpos  out  10  recovered row, 0..V_ACTIVE-1
  display_on  out  1  recovered pixel is in the active area and the block is locked
  line_start  out  1  one-clk pulse on each detected hsync leading edge
  frame_start  out  1  one-clk pulse on each detected vsync leading edge
  h_total  out  10  last measured line length in clocks
  v_total  out  10  last measured frame length in lines
  locked  out  1  high in LOCKED state
  sync_err  out  1  one-clk pulse when lock is lost or a timeout occurs

Function
REQ-008 SHALL pass each sync input through a 2-flop synchronizer, then detect its leading (falling) edge; a pin edge shall produce line_start/frame_start 3 clks later.
REQ-009 SHALL keep hcount (10 bit): set to 0 on an hsync edge, otherwise +1 per clk, saturating at 1023.
REQ-010 SHALL keep vcount (10 bit): +1 on each hsync edge, set to 0 on a vsync edge; when both edges occur in the same clk, vcount SHALL become 0.
REQ-011 SHALL latch h_total = hcount+1 on each hsync edge and v_total = vcount+1 on each vsync edge.
REQ-012 SHALL keep a per-frame frame_ok flag: set on a vsync edge, cleared on any hsync edge whose measured length is not H_TOTAL_EXP.
REQ-013 SHALL judge a frame good at a vsync edge iff frame_ok is set and vcount+1 equals V_TOTAL_EXP.
REQ-014 SHALL implement the FSM states SEARCH, CHECK and LOCKED:
  SEARCH -> CHECK on the first vsync edge, with good_cnt cleared to 0
  CHECK: a good frame increments good_cnt; on reaching LOCK_FRAMES the FSM moves to LOCKED; a bad frame clears good_cnt and stays in CHECK
  LOCKED: a bad frame -> SEARCH with a sync_err pulse
REQ-015 SHALL treat hcount reaching 1023 (hsync missing) as a timeout in any state: go to SEARCH; pulse sync_err once per timeout entry, but only if the state was not already SEARCH.
REQ-016 SHALL ignore line-length checks in SEARCH.
REQ-017 SHALL drive display_on = locked AND H_START<=hcount<H_START+H_ACTIVE AND V_START<=vcount<V_START+V_ACTIVE.
REQ-018 SHALL drive hpos = hcount-H_START and vpos = vcount-V_START while display_on is high, and 0 otherwise.
REQ-019 SHALL register all outputs, each aligned to the same clk as the hcount/vcount value it reflects.

Reset
REQ-020 SHALL, while reset_n is low, force state SEARCH; hcount, vcount, good_cnt, h_total, v_total, hpos and vpos to 0; synchronizer flops to 1 (sync inactive); and display_on, line_start, frame_start, locked and sync_err to 0.
REQ-021 SHALL, on deassertion mid-frame, restart in SEARCH and ignore the partial frame.

Verification
REQ-022 SHALL pass: standard 800x525 timing, 96-clk hsync, 2-line vsync -> locked rises on the 2nd good vsync edge after the first; h_total=800; v_total=525.
REQ-023 SHALL pass: locked, pixel at hcount 144 of line 35 -> display_on=1, hpos=0, vpos=0; at hcount 783 of line 514 -> hpos=639, vpos=479; hcount 784 -> display_on=0.
REQ-024 SHALL pass: locked, one line shortened to 799 clks -> at the next vsync edge locked=0 and sync_err pulses once, state is SEARCH, and relock follows after 1+LOCK_FRAMES vsync edges.
REQ-025 SHALL pass: hsync held high for 1100 clks while locked -> sync_err at hcount=1023, locked=0, and hcount holds at 1023.
REQ-026 SHALL pass: vsync and hsync edges in the same clk -> vcount=0, and v_total equals lines since the previous vsync.
REQ-027 SHALL pass: reset_n pulsed low mid-frame while locked -> all outputs 0 immediately and asynchronously, and lock is reacquired only after full good frames.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - recovers pixel position and lock status from raw VGA sync pins
module vga_sync_decoder #(
  parameter int H_TOTAL_EXP = 800,
  parameter int V_TOTAL_EXP = 525,
  parameter int H_START     = 144,
  parameter int V_START     = 35,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vga_h_sync,
  input  logic       vga_v_sync,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] h_total,
  output logic [9:0] v_total,
  output logic       locked,
  output logic       sync_err
);

  localparam logic [9:0] H_EXP  = 10'(H_TOTAL_EXP);
  localparam logic [9:0] V_EXP  = 10'(V_TOTAL_EXP);
  localparam logic [9:0] H_LO   = 10'(H_START);
  localparam logic [9:0] H_HI   = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_LO   = 10'(V_START);
  localparam logic [9:0] V_HI   = 10'(V_START + V_ACTIVE);
  localparam logic [9:0] HC_MAX = 10'd1023;
  localparam int         GW     = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
  localparam logic [GW-1:0] LF  = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t        state, state_d;
  logic [GW-1:0] good_cnt, good_cnt_d;
  logic [2:0]    hs_sr, vs_sr;
  logic          h_edge, v_edge;
  logic [9:0]    hcount, hcount_d, vcount, vcount_d;
  logic [9:0]    hlen, vlen;
  logic          frame_ok, frame_good, timeout, lost;
  logic          locked_d, disp_d;
  logic [9:0]    hpos_d, vpos_d;

  // [0],[1] synchronize; [2] holds the previous synchronized level for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_sr <= '1;
      vs_sr <= '1;
    end else begin
      hs_sr <= {hs_sr[1:0], vga_h_sync};
      vs_sr <= {vs_sr[1:0], vga_v_sync};
    end
  end

  assign h_edge = hs_sr[2] & ~hs_sr[1];
  assign v_edge = vs_sr[2] & ~vs_sr[1];

  always_comb begin
    hcount_d = hcount;
    if (h_edge)
      hcount_d = '0;
    else if (hcount != HC_MAX)
      hcount_d = hcount + 10'd1;
    vcount_d = vcount;
    if (v_edge)
      vcount_d = '0;
    else if (h_edge)
      vcount_d = vcount + 10'd1;
    hlen       = hcount + 10'd1;
    vlen       = vcount + 10'd1;
    timeout    = (hcount_d == HC_MAX);
    frame_good = frame_ok && (vlen == V_EXP);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_d;
      good_cnt <= good_cnt_d;
    end
  end

  // FSM: next state; a timeout outranks any frame verdict in the same clk
  always_comb begin
    state_d    = state;
    good_cnt_d = good_cnt;
    lost       = 1'b0;
    if (timeout) begin
      state_d = SEARCH;
      lost    = (state != SEARCH);
    end else if (v_edge) begin
      case (state)
        SEARCH: begin
          state_d    = CHECK;
          good_cnt_d = '0;
        end
        CHECK: begin
          if (frame_good) begin
            good_cnt_d = good_cnt + GW'(1);
            if (good_cnt_d >= LF)
              state_d = LOCKED;
          end else begin
            good_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (!frame_good) begin
            state_d = SEARCH;
            lost    = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // FSM: outputs, computed from next-cycle counters so they register in step with them
  always_comb begin
    locked_d = (state_d == LOCKED);
    disp_d   = locked_d && (hcount_d >= H_LO) && (hcount_d < H_HI) &&
               (vcount_d >= V_LO) && (vcount_d < V_HI);
    hpos_d   = disp_d ? (hcount_d - H_LO) : 10'd0;
    vpos_d   = disp_d ? (vcount_d - V_LO) : 10'd0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_ok    <= 1'b0;
      h_total     <= '0;
      v_total     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      display_on  <= 1'b0;
      hpos        <= '0;
      vpos        <= '0;
    end else begin
      hcount      <= hcount_d;
      vcount      <= vcount_d;
      if (v_edge)
        frame_ok <= 1'b1;
      else if (h_edge && (state != SEARCH) && (hlen != H_EXP))
        frame_ok <= 1'b0;
      if (h_edge)
        h_total <= hlen;
      if (v_edge)
        v_total <= vlen;
      line_start  <= h_edge;
      frame_start <= v_edge;
      locked      <= locked_d;
      sync_err    <= lost;
      display_on  <= disp_d;
      hpos        <= hpos_d;
      vpos        <= vpos_d;
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - randomized frame stimulus with a cycle-stamped scoreboard
module tb_vga_sync_decoder;
  localparam int HT = 40, VT = 20, HS0 = 8, VS0 = 3, HA = 24, VA = 14, LK = 2;
  localparam int HSW = 5, VSW = 2;

  logic       clk = 1'b0, reset_n = 1'b0, vga_h_sync = 1'b1, vga_v_sync = 1'b1;
  logic [9:0] hpos, vpos, h_total, v_total;
  logic       display_on, line_start, frame_start, locked, sync_err;

  vga_sync_decoder #(
    .H_TOTAL_EXP(HT), .V_TOTAL_EXP(VT), .H_START(HS0), .V_START(VS0),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .hpos(hpos), .vpos(vpos), .display_on(display_on), .line_start(line_start),
    .frame_start(frame_start), .h_total(h_total), .v_total(v_total),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint     stamp;
    logic       ls, fs, lk, err, disp, ht_chk;
    logic [9:0] hp, vp, ht, vt;
  } exp_t;

  exp_t expq[$];
  exp_t me;
  int   n_tests = 0, n_fail = 0;

  // behavioural model state: frame-level lock bookkeeping
  bit in_search = 1, lk_m = 0, ht_dc = 1, prev_good = 0;
  int run = 0, cnt = 0, prev_len = 0, rst_cnt = 0;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  always @(negedge clk) begin
    while (expq.size() > 0 && expq[0].stamp < cyc) void'(expq.pop_front());
    if (expq.size() > 0 && expq[0].stamp == cyc) begin
      me = expq.pop_front();
      chk("line_start", 10'(line_start), 10'(me.ls));
      chk("frame_start", 10'(frame_start), 10'(me.fs));
      chk("locked", 10'(locked), 10'(me.lk));
      chk("sync_err", 10'(sync_err), 10'(me.err));
      chk("display_on", 10'(display_on), 10'(me.disp));
      chk("hpos", hpos, me.hp);
      chk("vpos", vpos, me.vp);
      if (me.ls && me.ht_chk) chk("h_total", h_total, me.ht);
      if (me.fs) chk("v_total", v_total, me.vt);
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, 10'(locked), 10'd0);
    chk({tag, "_display_on"}, 10'(display_on), 10'd0);
    chk({tag, "_line_start"}, 10'(line_start), 10'd0);
    chk({tag, "_frame_start"}, 10'(frame_start), 10'd0);
    chk({tag, "_sync_err"}, 10'(sync_err), 10'd0);
    chk({tag, "_h_total"}, h_total, 10'd0);
    chk({tag, "_v_total"}, v_total, 10'd0);
    chk({tag, "_hpos"}, hpos, 10'd0);
    chk({tag, "_vpos"}, vpos, 10'd0);
  endtask

  // one line of pins; a pin change at cycle P shows up on the outputs at cycle P+3
  task automatic run_line(input int len, input int l, input int rst_k);
    for (int k = 0; k < len; k++) begin
      exp_t e;
      e = '{default: '0};
      e.ls = (k == 0);
      e.fs = (k == 0) && (l == 0);
      if (e.fs) begin
        e.vt = 10'(cnt + 1);
        cnt  = 0;
        if (in_search) begin
          in_search = 0;
          run = 0;
        end else if (prev_good) begin
          run++;
        end else begin
          if (lk_m) begin
            e.err = 1'b1;
            in_search = 1;
          end
          run = 0;
        end
        lk_m = !in_search && (run >= LK);
      end else if (e.ls) begin
        cnt++;
      end
      if (e.ls) begin
        e.ht_chk = !ht_dc;
        e.ht     = 10'((prev_len > 1024) ? 1024 : prev_len);
        ht_dc    = 0;
        prev_len = len;
      end
      if (k == 1023) begin
        if (!in_search) e.err = 1'b1;
        in_search = 1;
        lk_m = 0;
      end
      e.lk   = lk_m;
      e.disp = lk_m && (k >= HS0) && (k < HS0 + HA) && (l >= VS0) && (l < VS0 + VA);
      e.hp   = e.disp ? 10'(k - HS0) : 10'd0;
      e.vp   = e.disp ? 10'(l - VS0) : 10'd0;
      @(posedge clk);
      #1;
      vga_h_sync = (k >= HSW);
      vga_v_sync = (l >= VSW);
      e.stamp = cyc + 3;
      if (rst_cnt == 0) expq.push_back(e);
      if (k == rst_k) begin
        reset_n = 1'b0;
        #1;
        chk_zero("midrst");
        expq.delete();
        in_search = 1; run = 0; lk_m = 0; cnt = 0; ht_dc = 1; rst_cnt = 3;
      end else if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) reset_n = 1'b1;
      end
    end
  endtask

  // mode: 0 clean, 1 one short line, 2 one long line, 3 wrong line count, 4 hsync dropout
  task automatic run_frame(input int mode, input int rst_line);
    int  n, idx;
    int  lens[$];
    bit  good;
    n = VT;
    if (mode == 3) n = ($urandom_range(0, 1) == 0) ? VT - 1 : VT + 1;
    for (int i = 0; i < n; i++) lens.push_back(HT);
    idx = $urandom_range(0, n - 2);
    if (mode == 1) lens[idx] = HT - $urandom_range(1, 3);
    if (mode == 2) lens[idx] = HT + $urandom_range(1, 3);
    if (mode == 4) lens[6] = 1100;
    good = (n == VT);
    foreach (lens[i]) if (lens[i] != HT) good = 0;
    for (int l = 0; l < n; l++) run_line(lens[l], l, (l == rst_line) ? 20 : -1);
    prev_good = good;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    reset_n = 1'b1;
    repeat (4) run_frame(0, -1);
    run_frame(1, -1);
    repeat (4) run_frame(0, -1);
    run_frame(4, -1);
    repeat (12) run_frame(int'($urandom_range(0, 3)), -1);
    repeat (4) run_frame(0, -1);
    run_frame(0, 8);
    repeat (4) run_frame(0, -1);
    repeat (6) @(posedge clk);
    chk("scoreboard_drained", 10'(expq.size()), 10'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
